// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// default bus widths and port-index constants.
package memory_arbiter_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 32;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE0 = 3'd1,
      WAIT0  = 3'd2,
      ISSUE1 = 3'd3,
      WAIT1  = 3'd4
   } arb_state_t;

   function automatic arb_state_t issue_state(input logic port);
      return (port == PORT_D) ? ISSUE1 : ISSUE0;
   endfunction

endpackage

// File: rtl/memory_arbiter_arb_rr2.sv
// Two-requester round-robin picker: on a collision the port that was not
// granted last wins; otherwise the single requester is chosen.
module memory_arbiter_arb_rr2
   import memory_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_grant
);

   always_comb begin
      o_grant = PORT_I;
      if (i_req == 2'b11) begin
         o_grant = ~i_last;
      end else if (i_req[PORT_D]) begin
         o_grant = PORT_D;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one main-memory port between the icache refill path (port 0) and the
// dcache refill/write-back path (port 1), serialising block transfers.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              P0_READ,
   input  logic              P0_WRITE,
   input  logic [ADDR_W-1:0] P0_ADDRESS,
   input  logic [DATA_W-1:0] P0_WRITEDATA,
   output logic [DATA_W-1:0] P0_READDATA,
   output logic              P0_BUSYWAIT,
   input  logic              P1_READ,
   input  logic              P1_WRITE,
   input  logic [ADDR_W-1:0] P1_ADDRESS,
   input  logic [DATA_W-1:0] P1_WRITEDATA,
   output logic [DATA_W-1:0] P1_READDATA,
   output logic              P1_BUSYWAIT,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [ADDR_W-1:0] MEM_ADDRESS,
   output logic [DATA_W-1:0] MEM_WRITEDATA,
   input  logic [DATA_W-1:0] MEM_READDATA,
   input  logic              MEM_BUSYWAIT
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              r_last;
   logic              w_last_nxt;
   logic [DATA_W-1:0] r_p0_rdata;
   logic [DATA_W-1:0] r_p1_rdata;

   logic w_p0_req;
   logic w_p1_req;
   logic w_grant;
   logic w_serve0;
   logic w_serve1;
   logic w_done0;
   logic w_done1;

   assign w_p0_req = P0_READ | P0_WRITE;
   assign w_p1_req = P1_READ | P1_WRITE;

   assign w_serve0 = (r_state == ISSUE0) || (r_state == WAIT0);
   assign w_serve1 = (r_state == ISSUE1) || (r_state == WAIT1);
   assign w_done0  = (r_state == WAIT0) && !MEM_BUSYWAIT;
   assign w_done1  = (r_state == WAIT1) && !MEM_BUSYWAIT;

   memory_arbiter_arb_rr2 u_arb_rr2 (
      .i_req   ({w_p1_req, w_p0_req}),
      .i_last  (r_last),
      .o_grant (w_grant)
   );

   // ISSUE lasts exactly one cycle regardless of MEM_BUSYWAIT, so memory
   // always sees the request before its busy flag is trusted.
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      case (r_state)
         IDLE: begin
            if (w_p0_req || w_p1_req) begin
               w_state_nxt = issue_state(w_grant);
            end
         end
         ISSUE0: w_state_nxt = WAIT0;
         WAIT0: begin
            if (!MEM_BUSYWAIT) begin
               w_state_nxt = IDLE;
               w_last_nxt  = PORT_I;
            end
         end
         ISSUE1: w_state_nxt = WAIT1;
         WAIT1: begin
            if (!MEM_BUSYWAIT) begin
               w_state_nxt = IDLE;
               w_last_nxt  = PORT_D;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state <= IDLE;
         r_last  <= PORT_I;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Each port keeps the last word it was shown once its transfer ends.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_p0_rdata <= '0;
         r_p1_rdata <= '0;
      end else begin
         if (w_serve0) begin
            r_p0_rdata <= MEM_READDATA;
         end
         if (w_serve1) begin
            r_p1_rdata <= MEM_READDATA;
         end
      end
   end

   // A simultaneous read+write is forwarded as a write only.
   always_comb begin
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
      if (w_serve0) begin
         MEM_READ      = P0_READ & ~P0_WRITE;
         MEM_WRITE     = P0_WRITE;
         MEM_ADDRESS   = P0_ADDRESS;
         MEM_WRITEDATA = P0_WRITEDATA;
      end else if (w_serve1) begin
         MEM_READ      = P1_READ & ~P1_WRITE;
         MEM_WRITE     = P1_WRITE;
         MEM_ADDRESS   = P1_ADDRESS;
         MEM_WRITEDATA = P1_WRITEDATA;
      end
   end

   assign P0_BUSYWAIT = w_p0_req & ~w_done0;
   assign P1_BUSYWAIT = w_p1_req & ~w_done1;

   assign P0_READDATA = w_serve0 ? MEM_READDATA : r_p0_rdata;
   assign P1_READDATA = w_serve1 ? MEM_READDATA : r_p1_rdata;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter that shares one main-memory port between the instruction-cache refill path (port 0) and the data-cache refill/write-back path (port 1). It sits between both caches and a single unified memory. It serialises their block transfers with round-robin priority and stalls the losing cache through its BUSYWAIT, so the two caches no longer need separate memories.

## Interface
- ADDR_W, 6, block address width (both ports and memory)
- DATA_W, 32, block data width (both ports and memory)
- CLK  in  1  clock; all state changes on posedge
- RESET  in  1  synchronous, active-low; sampled on posedge CLK
- P0_READ, P1_READ  in  1  read request from port 0 / port 1
- P0_WRITE, P1_WRITE  in  1  write request; P0_WRITE is tied 0 by the icache but is honoured
- P0_ADDRESS, P1_ADDRESS  in  ADDR_W  block address
- P0_WRITEDATA, P1_WRITEDATA  in  DATA_W  write block
- P0_READDATA, P1_READDATA  out  DATA_W  read block returned to the port
- P0_BUSYWAIT, P1_BUSYWAIT  out  1  stall to the requesting cache
- MEM_READ, MEM_WRITE  out  1  forwarded request to memory
- MEM_ADDRESS  out  ADDR_W; MEM_WRITEDATA  out  DATA_W
- MEM_READDATA  in  DATA_W; MEM_BUSYWAIT  in  1  memory busy

## Operation
- A port requests when READ|WRITE = 1. It holds READ/WRITE/ADDRESS/WRITEDATA stable until its BUSYWAIT is low at a posedge. If READ and WRITE are both 1, the request is a write: MEM_READ is forced to 0.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1.
- IDLE: no memory request. At the posedge, if only one port is requesting, go to ISSUEx for that port. If both are requesting, go to ISSUE of the port not granted last (round-robin pointer LAST). LAST resets to 0, so port 1 wins the first collision.
- ISSUEx: forward port x's signals to the MEM_* outputs (combinational mux on state). Always advance to WAITx after exactly 1 cycle; MEM_BUSYWAIT is ignored in this cycle.
- WAITx: keep forwarding. At the posedge where MEM_BUSYWAIT = 0, the transfer completes: go to IDLE and set LAST = x.
- Px_BUSYWAIT = Px request AND NOT (state == WAITx AND MEM_BUSYWAIT == 0). The losing or not-yet-granted port stalls for the same cycle it raises its request.
- Px_READDATA = MEM_READDATA when state is ISSUEx or WAITx, else holds the last value driven to that port (registered hold). It is valid in the completion cycle.
- MEM_* outputs are all 0 in IDLE.
- A request that drops while in ISSUEx/WAITx is a protocol error. The arbiter still waits for the MEM_BUSYWAIT fall before returning to IDLE.

## Timing
- Reset (RESET = 0 at posedge): state IDLE, LAST = 0, MEM_READ/MEM_WRITE = 0, MEM_ADDRESS = 0, MEM_WRITEDATA = 0, Px_READDATA = 0. Px_BUSYWAIT follows its combinational rule, so it is 0 when there is no request.
- Reset mid-transaction aborts the memory request on the next edge (MEM_READ/WRITE = 0). The requester keeps BUSYWAIT high and is re-arbitrated from IDLE.
- Uncontended latency: request seen at edge t, ISSUE in cycle t..t+1, WAIT from edge t+1, completion at the first edge t+1+k with MEM_BUSYWAIT = 0. Arbitration overhead is 2 cycles (IDLE sample plus ISSUE) on top of memory latency.
- Between transfers there is a mandatory 1-cycle IDLE gap, so memory sees READ/WRITE deasserted before the next request.
- Both ports requesting continuously: grants alternate strictly. Neither port waits more than one full transfer of the other.

## Structure
- Shared package holds the state encoding constants (IDLE = 0, ISSUE0 = 1, WAIT0 = 2, ISSUE1 = 3, WAIT1 = 4), the default ADDR_W/DATA_W values, and port-index constants PORT_I = 0 and PORT_D = 1.
- There is one natural sub-module, arb_rr2: a 2-requester round-robin picker with inputs req[1:0] and last, output grant index.
- The cpu_tb top level instantiates memory_arbiter between instruction_cache, data_cache and one data_memory-style unified memory.

## Test plan
- Reset, then P0_READ = 1 with ADDRESS = 6'h05, memory latency 5 -> MEM_READ = 1 and MEM_ADDRESS = 5 from the cycle after request. P0_BUSYWAIT falls exactly at MEM_BUSYWAIT fall. P0_READDATA = memory word. P1_BUSYWAIT = 0 throughout.
- P0_READ and P1_READ raised in the same cycle after reset -> port 1 is served first, then a 1-cycle IDLE, then port 0. P0_BUSYWAIT stays 1 until its own completion.
- Both ports requesting back-to-back for 4 transfers -> grant order 1, 0, 1, 0. MEM_ADDRESS alternates between the two port addresses.
- P1_WRITE = 1, ADDRESS = 6'h3F, WRITEDATA = 32'hDEADBEEF -> MEM_WRITE = 1, MEM_READ = 0, MEM_ADDRESS = 3F, MEM_WRITEDATA = DEADBEEF. A later read of 3F via port 0 returns DEADBEEF.
- P1_READ = P1_WRITE = 1 -> forwarded as a write only (MEM_READ = 0).
- RESET = 0 during WAIT0 -> at the next edge MEM_READ = 0, state is IDLE, Px_READDATA = 0. After release, the still-pending P0 request is re-issued and completes normally.
